// File: rtl/bsg_fifo_1r1w_latch.sv
// Latch-backed 1R1W FIFO: valid/ready enqueue, valid/yumi dequeue.
// Writes land in a latch one cycle after acceptance; heads are muxed out.
module bsg_fifo_1r1w_latch #(
  parameter int width_p = 16,
  parameter int els_p = 4,
  parameter int i_know_this_is_a_bad_idea_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int pw_lp = $clog2(els_p);
  localparam int cw_lp = $clog2(els_p+1);
  localparam logic [pw_lp-1:0] last_lp = pw_lp'(els_p-1);
  localparam logic [cw_lp-1:0] full_lp = cw_lp'(els_p);

  if (i_know_this_is_a_bad_idea_p != 1) begin : g_ack
    $error("latch storage must be acknowledged");
  end

  logic [pw_lp-1:0]   wptr_r;
  logic [pw_lp-1:0]   rptr_r;
  logic [pw_lp-1:0]   waddr_r;
  logic [width_p-1:0] wdata_r;
  logic               we_r;
  logic [cw_lp-1:0]   count_r;
  logic [cw_lp-1:0]   vcount_r;
  logic [cw_lp-1:0]   count_n;
  logic [cw_lp-1:0]   vcount_n;
  logic [width_p-1:0] mem_r [els_p];
  logic               enq;
  logic               deq;

  function automatic logic [pw_lp-1:0] inc
    (input logic [pw_lp-1:0] p);
    return (p == last_lp) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = ~reset_i & (count_r != full_lp);
  assign v_o     = (vcount_r != '0);
  assign count_o = count_r;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rptr_r] & {width_p{v_o}};

  // next occupancy (incl. pending write) and visible count
  always_comb begin
    count_n  = count_r;
    vcount_n = vcount_r;
    if (enq & ~deq)
      count_n = count_r + 1'b1;
    else if (deq & ~enq)
      count_n = count_r - 1'b1;
    if (we_r & ~deq)
      vcount_n = vcount_r + 1'b1;
    else if (deq & ~we_r)
      vcount_n = vcount_r - 1'b1;
  end

  // pointers, staged write and counters
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      waddr_r  <= '0;
      wdata_r  <= '0;
      we_r     <= 1'b0;
      count_r  <= '0;
      vcount_r <= '0;
    end else begin
      we_r     <= enq;
      count_r  <= count_n;
      vcount_r <= vcount_n;
      if (enq) begin
        wdata_r <= data_i;
        waddr_r <= wptr_r;
        wptr_r  <= inc(wptr_r);
      end
      if (deq)
        rptr_r <= inc(rptr_r);
    end
  end

  // entry is transparent in the low phase after its write is staged
  always_latch begin
    for (int i = 0; i < els_p; i++)
      if (~clk_i & we_r & (waddr_r == pw_lp'(i)))
        mem_r[i] <= wdata_r;
  end

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o));

endmodule
